seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_mul_pkg.sv | 23 ++
 rtl/seq_multiplier.sv | 126 ++++++++++++
 2 files changed

// File: rtl/seq_mul_pkg.sv
// Shared constants for the sequential multiplier: register offsets, the fixed
// iteration count, and a two's-complement magnitude helper.
package seq_mul_pkg;

  localparam logic [7:0] ADDR_INFO   = 8'h00;
  localparam logic [7:0] ADDR_MUL_A  = 8'h04;
  localparam logic [7:0] ADDR_MUL_B  = 8'h08;
  localparam logic [7:0] ADDR_RES_HI = 8'h0C;
  localparam logic [7:0] ADDR_RES_LO = 8'h10;
  localparam logic [7:0] ADDR_CTRL   = 8'h14;

  // One multiplier bit is consumed per busy cycle.
  localparam int              MUL_CYCLES = 32;
  localparam int              CNT_W      = 6;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MUL_CYCLES);

  // Magnitude of a two's-complement word. 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Register-mapped 32x32 -> 64 radix-2 shift-add multiplier.
// A write to MUL_B starts a 32-cycle operation; results land in RES_HI/RES_LO.
// Optional feature: define SEQ_MUL_SIGNED_EN to add the CTRL register
// (bit0 = signed mode, sampled when MUL_B is written).
module seq_multiplier
  import seq_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        we,
  input  logic        re
);

  // Reads are side-effect free, so the read strobe carries no information.
  logic unused_re;
  assign unused_re = re;

  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             busy;
  logic [63:0]      work_a;   // multiplicand, shifted left each step
  logic [31:0]      work_b;   // multiplier, shifted right each step
  logic [63:0]      acc;
  logic [CNT_W-1:0] count;

  logic             wr_a;
  logic             wr_b;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [63:0]      acc_next;
  logic [63:0]      product;
  logic             last_step;

  assign wr_a      = we && (address == ADDR_MUL_A);
  assign wr_b      = we && (address == ADDR_MUL_B);
  assign acc_next  = acc + (work_b[0] ? work_a : 64'd0);
  assign last_step = busy && (count == 1);

`ifdef SEQ_MUL_SIGNED_EN
  logic ctrl_signed;
  logic neg;
  logic wr_ctrl;

  assign wr_ctrl = we && (address == ADDR_CTRL);
  // In signed mode the loop works on magnitudes; the sign is fixed up at the end.
  assign op_a    = ctrl_signed ? abs32(mul_a) : mul_a;
  assign op_b    = ctrl_signed ? abs32(write_data) : write_data;
  assign product = neg ? (64'd0 - acc_next) : acc_next;
`else
  assign op_a    = mul_a;
  assign op_b    = write_data;
  assign product = acc_next;
`endif

  // Register file, operation start/abort, and one shift-add step per busy cycle.
  // NOTE: state is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, exactly like the flops they become.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      res_hi <= '0;
      res_lo <= '0;
      busy   <= 1'b0;
      work_a <= '0;
      work_b <= '0;
      acc    <= '0;
      count  <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      ctrl_signed <= 1'b0;
      neg         <= 1'b0;
`endif
    end else begin
      if (wr_a) mul_a <= write_data;
`ifdef SEQ_MUL_SIGNED_EN
      if (wr_ctrl) ctrl_signed <= write_data[0];
`endif
      // A MUL_B write wins over a completing operation: restart, no result.
      if (wr_b) begin
        mul_b  <= write_data;
        work_a <= {32'd0, op_a};
        work_b <= op_b;
        acc    <= '0;
        count  <= CNT_LOAD;
        busy   <= 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
        neg    <= ctrl_signed && (mul_a[31] ^ write_data[31]);
`endif
      end else if (busy) begin
        acc    <= acc_next;
        work_a <= work_a << 1;
        work_b <= work_b >> 1;
        count  <= count - 1'b1;
        if (last_step) begin
          busy   <= 1'b0;
          res_hi <= product[63:32];
          res_lo <= product[31:0];
        end
      end
    end
  end

  // Combinational read mux; unmapped offsets read as zero.
  // NOTE: read_data gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    read_data = '0;
    case (address)
      ADDR_INFO:   read_data = {31'd0, ~busy};
      ADDR_MUL_A:  read_data = mul_a;
      ADDR_MUL_B:  read_data = mul_b;
      ADDR_RES_HI: read_data = res_hi;
      ADDR_RES_LO: read_data = res_lo;
`ifdef SEQ_MUL_SIGNED_EN
      ADDR_CTRL:   read_data = {31'd0, ctrl_signed};
`endif
      default:     read_data = '0;
    endcase
  end

endmodule
